// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
// Fetch sequencer between a combinational, word-addressed instruction ROM and
// the decode stage. It owns the program counter, pushes one ROM word per cycle
// into a small instruction FIFO and presents the FIFO head over valid/ready.
// Redirects flush the FIFO and restart fetching at a new PC. A fetch beyond
// the end of the ROM produces a single error entry and halts fetching until
// the next redirect.
//
// Ports
//   clk_i, rst_ni           core clock, async active-low reset
//   fetch_en_i              allow new ROM fetches (buffered entries still drain)
//   redirect_i/_pc_i        one-cycle flush + restart at redirect_pc_i & ~3
//   rom_addr_o/rom_en_o     byte address and enable to the ROM
//   rom_instr_i             ROM data, combinational in the same cycle
//   instr_o/instr_pc_o      FIFO head instruction and its PC
//   instr_err_o             head came from an out-of-range address (instr_o = 0)
//   instr_valid_o/ready_i   decode handshake
//   busy_o                  fetching, or instructions still buffered
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | fetching disabled, pc held; FIFO may still be draining
// RUN   | one fetch per cycle whenever the FIFO has (or frees) a slot
// HALT  | out-of-range entry pushed; waits for a redirect

module instr_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          ROM_WORDS  = 2048,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_en_o,
    input  logic [31:0] rom_instr_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_err_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [31:0]     ADDR_LIMIT = 32'(ROM_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    pc_q;
    logic [31:0]    fifo_instr [FIFO_DEPTH];
    logic [31:0]    fifo_pc    [FIFO_DEPTH];
    logic           fifo_err   [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;

    logic           head_taken;
    logic           pop;
    logic           space;
    logic           fetch_go;
    logic           pc_err;
    logic [31:0]    push_instr;

    assign instr_valid_o = (count_q != '0);
    assign head_taken    = instr_valid_o & instr_ready_i;
    // A head taken during a redirect is the one being flushed, so it is not a pop.
    assign pop           = head_taken & ~redirect_i;
    assign space         = (count_q < DEPTH_C) | head_taken;
    assign fetch_go      = (state_q == RUN) & ~redirect_i & space;
    assign pc_err        = (pc_q >= ADDR_LIMIT);
    // Out-of-range fetches never enable the ROM; the entry carries a zero word.
    assign rom_en_o      = fetch_go & ~pc_err;
    assign rom_addr_o    = pc_q;
    assign push_instr    = pc_err ? 32'h0 : rom_instr_i;

    assign instr_o       = instr_valid_o ? fifo_instr[rd_ptr_q] : 32'h0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc[rd_ptr_q]    : 32'h0;
    assign instr_err_o   = instr_valid_o & fifo_err[rd_ptr_q];
    assign busy_o        = (state_q == RUN) | instr_valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = fetch_en_i ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE: if (fetch_en_i) state_d = RUN;
                RUN: begin
                    if (fetch_go && pc_err) state_d = HALT;
                    else if (!fetch_en_i)   state_d = IDLE;
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q     <= BOOT_ADDR;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_i) begin
            pc_q     <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fetch_go) begin
                pc_q     <= pc_q + 32'd4;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({fetch_go, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: every output read is gated by the count.
    always_ff @(posedge clk_i) begin
        if (fetch_go) begin
            fifo_instr[wr_ptr_q] <= push_instr;
            fifo_pc[wr_ptr_q]    <= pc_q;
            fifo_err[wr_ptr_q]   <= pc_err;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

    localparam logic [31:0] BOOT       = 32'h0000_0000;
    localparam int          ROM_WORDS  = 2048;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] LIMIT      = 32'(ROM_WORDS * 4);
    localparam int          M_IDLE = 0, M_RUN = 1, M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_instr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_err;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .BOOT_ADDR (BOOT),
        .ROM_WORDS (ROM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .fetch_en_i   (fetch_en),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .rom_addr_o   (rom_addr),
        .rom_en_o     (rom_en),
        .rom_instr_i  (rom_instr),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_err_o  (instr_err),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .busy_o       (busy)
    );

    function automatic logic [31:0] rom_fn(input logic [29:0] idx);
        case (idx)
            30'd0:   return 32'h11;
            30'd1:   return 32'h22;
            30'd2:   return 32'h33;
            30'd3:   return 32'h44;
            default: return ({2'b00, idx} * 32'h9E37_79B1) + 32'h1;
        endcase
    endfunction

    always_comb rom_instr = rom_en ? rom_fn(rom_addr[31:2]) : 32'h0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          mode;
    logic [31:0] acc[$];

    task automatic model_reset();
        mq.delete();
        mpc  = BOOT;
        mode = M_IDLE;
    endtask

    task automatic model_step();
        bit   popv, go, err;
        ent_t e;
        if (redirect) begin
            mq.delete();
            mpc  = {redirect_pc[31:2], 2'b00};
            mode = fetch_en ? M_RUN : M_IDLE;
            return;
        end
        popv = (mq.size() != 0) && instr_ready;
        go   = (mode == M_RUN) && ((mq.size() < FIFO_DEPTH) || popv);
        err  = (mpc >= LIMIT);
        if (popv) void'(mq.pop_front());
        if (go) begin
            e.pc    = mpc;
            e.err   = err;
            e.instr = err ? 32'h0 : rom_fn(mpc[31:2]);
            mq.push_back(e);
            mpc = mpc + 32'd4;
        end
        if (mode == M_IDLE) begin
            if (fetch_en) mode = M_RUN;
        end else if (mode == M_RUN) begin
            if (go && err)      mode = M_HALT;
            else if (!fetch_en) mode = M_IDLE;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit          v, go, ren;
        logic [31:0] ei, ep;
        logic        ee;
        v  = (mq.size() != 0);
        ei = v ? mq[0].instr : 32'h0;
        ep = v ? mq[0].pc    : 32'h0;
        ee = v ? mq[0].err   : 1'b0;
        go  = (mode == M_RUN) && !redirect && ((mq.size() < FIFO_DEPTH) || (v && instr_ready));
        ren = go && (mpc < LIMIT);
        chk("valid",    {31'b0, instr_valid}, {31'b0, v});
        chk("instr",    instr,    ei);
        chk("instr_pc", instr_pc, ep);
        chk("err",      {31'b0, instr_err}, {31'b0, ee});
        chk("rom_en",   {31'b0, rom_en},    {31'b0, ren});
        chk("rom_addr", rom_addr, mpc);
        chk("busy",     {31'b0, busy}, {31'b0, (mode == M_RUN) || v});
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
        fetch_en    = fe;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic advance();
        if (instr_valid && instr_ready && !redirect) acc.push_back(instr_pc);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc(input logic fe, input logic rdy, input logic rd, input logic [31:0] rpc);
        drive(fe, rdy, rd, rpc);
        check_model();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    instr_pc, 32'h0);
        chk("rst_err",   {31'b0, instr_err}, 32'h0);
        chk("rst_rom_en", {31'b0, rom_en}, 32'h0);
        chk("rst_rom_addr", rom_addr, BOOT);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        acc.delete();
    endtask

    // Runs with fetch/ready high until a valid head appears; returns its PC.
    task automatic wait_valid(input string nm, output logic [31:0] pc);
        bit found = 0;
        pc = 32'hDEAD_BEEF;
        for (int i = 0; i < 10 && !found; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            check_model();
            if (instr_valid) begin
                found = 1;
                pc    = instr_pc;
            end
            advance();
        end
        if (!found) chk({nm, "_timeout"}, 32'h0, 32'h1);
    endtask

    typedef struct {
        bit          rst;
        logic        fe;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic        eren;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] p, last_pc;
        bit          seen_ok, seen_err, busy_bad;

        rst_n = 1'b0;
        model_reset();

        // startup stream, then ready held low to fill the buffer
        tbl.push_back('{1, 1, 1, 0, 32'h0, 32'h00, 0, 32'h00});
        tbl.push_back('{0, 1, 1, 0, 32'h0, 32'h00, 1, 32'h00});
        tbl.push_back('{0, 1, 1, 1, 32'h0, 32'h11, 1, 32'h04});
        tbl.push_back('{0, 1, 1, 1, 32'h4, 32'h22, 1, 32'h08});
        tbl.push_back('{0, 1, 1, 1, 32'h8, 32'h33, 1, 32'h0C});
        tbl.push_back('{0, 1, 1, 1, 32'hC, 32'h44, 1, 32'h10});
        tbl.push_back('{1, 1, 0, 0, 32'h0, 32'h00, 0, 32'h00});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 32'h00, 1, 32'h00});
        tbl.push_back('{0, 1, 0, 1, 32'h0, 32'h11, 1, 32'h04});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{0, 1, 0, 1, 32'h0, 32'h11, 0, 32'h08});
        tbl.push_back('{0, 1, 1, 1, 32'h0, 32'h11, 1, 32'h08});
        tbl.push_back('{0, 1, 1, 1, 32'h4, 32'h22, 1, 32'h0C});
        tbl.push_back('{0, 1, 1, 1, 32'h8, 32'h33, 1, 32'h10});

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].fe, tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_pc", i),    instr_pc, tbl[i].epc);
                chk($sformatf("tbl%0d_instr", i), instr,    tbl[i].ein);
            end
            chk($sformatf("tbl%0d_rom_en", i),   {31'b0, rom_en}, {31'b0, tbl[i].eren});
            chk($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].eaddr);
            check_model();
            advance();
        end

        // redirect while PCs 8 and C are buffered; head taken in that cycle is flushed
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 32'h0);
        cyc(1, 0, 0, 32'h0);
        chk("redir_pre_pc", instr_pc, 32'h8);
        acc.delete();
        cyc(1, 1, 1, 32'h103);
        drive(1, 1, 0, 32'h0);
        chk("redir_valid_drop", {31'b0, instr_valid}, 32'h0);
        check_model();
        advance();
        drive(1, 1, 0, 32'h0);
        chk("redir_lat_valid", {31'b0, instr_valid}, 32'h1);
        chk("redir_first_pc", instr_pc, 32'h100);
        check_model();
        advance();
        for (int i = 0; i < 6; i++) cyc(1, 1, 0, 32'h0);
        chk("redir_acc_first", (acc.size() != 0) ? acc[0] : 32'hFFFF_FFFF, 32'h100);
        foreach (acc[k]) if (acc[k] == 32'h8 || acc[k] == 32'hC) chk("redir_stale_pc", acc[k], 32'h100);

        // end of ROM: last word fine, next one errors and halts
        cyc(1, 1, 1, 32'h1FFC);
        seen_ok  = 0;
        seen_err = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 32'h0);
            check_model();
            if (instr_valid && instr_pc == 32'h1FFC) begin
                seen_ok = 1;
                chk("end_ok_err", {31'b0, instr_err}, 32'h0);
            end
            if (instr_valid && instr_pc == 32'h2000) begin
                seen_err = 1;
                chk("end_err_flag", {31'b0, instr_err}, 32'h1);
                chk("end_err_instr", instr, 32'h0);
            end
            advance();
        end
        chk("end_seen_ok", {31'b0, seen_ok}, 32'h1);
        chk("end_seen_err", {31'b0, seen_err}, 32'h1);
        drive(1, 1, 0, 32'h0);
        chk("halt_rom_en", {31'b0, rom_en}, 32'h0);
        chk("halt_busy", {31'b0, busy}, 32'h0);
        advance();
        cyc(1, 1, 1, 32'h0);
        wait_valid("halt_resume", p);
        chk("halt_resume_pc", p, 32'h0);

        // fetch disabled with two entries buffered
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        cyc(0, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        chk("fe_off_busy", {31'b0, busy}, 32'h1);
        chk("fe_off_valid", {31'b0, instr_valid}, 32'h1);
        advance();
        last_pc  = 32'h0;
        busy_bad = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 32'h0);
            check_model();
            if (instr_valid) begin
                last_pc = instr_pc;
                if (!busy) busy_bad = 1;
            end
            advance();
        end
        chk("drain_busy_held", {31'b0, busy_bad}, 32'h0);
        drive(0, 1, 0, 32'h0);
        chk("drain_busy_low", {31'b0, busy}, 32'h0);
        chk("drain_empty", {31'b0, instr_valid}, 32'h0);
        advance();
        wait_valid("resume", p);
        chk("resume_pc", p, last_pc + 32'd4);

        // asynchronous reset with the buffer full
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h0);
        chk("full_before_rst", {31'b0, instr_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_rom_addr", rom_addr, BOOT);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_valid("arst_restart", p);
        chk("arst_first_pc", p, BOOT);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 3))
                0:       rpc = $urandom_range(0, 63);
                1:       rpc = 32'h1FE8 + $urandom_range(0, 23);
                2:       rpc = $urandom();
                default: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 24) == 0), rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer that drives the core's combinational, word-addressed instruction ROM.
- Owns the program counter and buffers fetched words in a small FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (with flush) and out-of-range fetches; sits between the ROM and the decode stage.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.
- ROM_WORDS, 2048, ROM depth in 32-bit words; valid byte addresses are 0 .. ROM_WORDS*4-1.
- FIFO_DEPTH, 2, instruction buffer entries; must be 2 or 4.

Ports:
- clk_i  input  1  core clock; all state changes on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- fetch_en_i  input  1  permits new ROM fetches; buffered entries still drain when low.
- redirect_i  input  1  one-cycle pulse: flush buffered instructions and restart at redirect_pc_i.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0).
- rom_addr_o  output  32  byte address to ROM (ROM indexes with [31:2]).
- rom_en_o  output  1  ROM enable; ROM returns 0 when low.
- rom_instr_i  input  32  ROM read data, combinational from rom_addr_o/rom_en_o in the same cycle.
- instr_o  output  32  instruction at FIFO head.
- instr_pc_o  output  32  PC of instr_o.
- instr_err_o  output  1  head entry came from an out-of-range address; instr_o is 0.
- instr_valid_o  output  1  FIFO head valid.
- instr_ready_i  input  1  decode accepts head when valid and ready are both high.
- busy_o  output  1  FSM in RUN, or FIFO not empty.

Behaviour:
- Clock and reset: one clock domain (clk_i); asynchronous active-low reset (rst_ni).
- Reset values:
  - pc_q = BOOT_ADDR; FIFO empty; FSM = IDLE.
  - rom_en_o = 0, rom_addr_o = BOOT_ADDR.
  - instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, instr_err_o = 0, busy_o = 0.
  - Reset mid-operation discards all FIFO contents immediately.
- FSM states IDLE, RUN, HALT:
  - IDLE -> RUN when fetch_en_i = 1.
  - RUN -> IDLE when fetch_en_i = 0 (pc_q is held).
  - RUN -> HALT when an out-of-range entry is pushed.
  - HALT -> RUN on redirect_i if fetch_en_i = 1, otherwise HALT -> IDLE on redirect_i.
  - IDLE -> RUN also on redirect_i with fetch_en_i = 1.
- Fetch condition (fetch_go): state = RUN, redirect_i = 0, and space available (count < FIFO_DEPTH, or a pop occurs in the same cycle).
- rom_en_o = fetch_go; rom_addr_o = pc_q always.
- On fetch_go, one push per cycle, zero-latency from the ROM:
  - Entry = {rom_instr_i, pc_q, err}, where err = (pc_q >= ROM_WORDS*4).
  - For an err entry, instr is forced to 0 and rom_en_o stays low that cycle.
  - pc_q <= pc_q + 4, with 32-bit wrap.
- Pushed entry is visible at instr_o/instr_valid_o on the next cycle. Latency from redirect to first valid instruction is 2 cycles.
- Pop: instr_valid_o & instr_ready_i. Push and pop in the same cycle with FIFO full is allowed; count is unchanged.
- Redirect has priority over everything:
  - FIFO flushed, so instr_valid_o = 0 next cycle.
  - No push and no pop-acceptance are recorded that cycle; a head consumed in the redirect cycle is the same instruction being flushed.
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - rom_en_o = 0 in the redirect cycle.
- HALT: no fetches, rom_en_o = 0; the FIFO drains normally, including the err entry.
- Back-to-back redirects: the last one wins; each one re-flushes.
- fetch_en_i deasserted with FIFO not empty: entries remain valid and drain; busy_o stays high until empty.
- Sustained throughput: 1 instruction/cycle while instr_ready_i = 1.

Test Plan:
1. Reset release, fetch_en_i = 1, ready = 1, ROM[0..3] = 11,22,33,44: instr_valid_o rises cycle 2; instr_o/instr_pc_o = 11/0, 22/4, 33/8, 44/C on consecutive cycles; rom_en_o high every cycle.
2. ready = 0 for 5 cycles after first valid: exactly FIFO_DEPTH entries (PCs 0, 4) buffered, rom_en_o = 0, pc_q = 8; ready = 1 gives 0, 4, 8 with no gaps or duplicates.
3. redirect_i pulse, redirect_pc_i = 0x103, while FIFO holds PCs 8 and C: valid drops next cycle, the next instruction has instr_pc_o = 0x100, and PCs 8/C are never accepted afterwards.
4. redirect to 0x1FFC with ROM_WORDS = 2048: entry PC 0x1FFC has err = 0; entry PC 0x2000 has instr_err_o = 1, instr_o = 0; FSM enters HALT, rom_en_o stays 0; redirect to 0 resumes at PC 0.
5. fetch_en_i dropped mid-stream with 2 entries buffered: both drain, busy_o falls after the last pop; re-enable resumes at the next sequential PC.
6. rst_ni asserted asynchronously mid-cycle with FIFO full: instr_valid_o = 0 immediately; after release the first instr_pc_o = BOOT_ADDR.
